// File: rtl/fir_pkg.sv
// Shared FIR output-stage types and the signed saturation helper.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package fir_pkg;

    typedef enum logic {
        ROUND_TRUNC   = 1'b0,
        ROUND_HALF_UP = 1'b1
    } round_mode_e;

    // Widest intermediate value the saturation helper accepts.
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                        ovf;
        logic signed [SAT_MAX_W-1:0] value;
    } sat_res_t;

    // Clip a signed value to the range of a signed 'width'-bit number.
    // The result is still SAT_MAX_W wide. Its low 'width' bits hold the clipped sample.
    function automatic sat_res_t sat_signed(input logic signed [SAT_MAX_W-1:0] value,
                                            input int                          width);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_res_t                    res;
        hi        = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo        = -(64'sd1 <<< (width - 1));
        res.ovf   = 1'b0;
        res.value = value;
        if (value > hi) begin
            res.ovf   = 1'b1;
            res.value = hi;
        end else if (value < lo) begin
            res.ovf   = 1'b1;
            res.value = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous show-ahead FIFO. The head word is visible on rd_data whenever the FIFO is not empty.
// Latency: a write at edge n is visible on rd_data/empty after edge n.
// Backpressure: exposes full/empty only. The parent decides what to do with a write while full.
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_fire;

    // An extra wrap bit on the pointers tells full apart from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update. A read on an empty FIFO is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage write. When full, a simultaneous read frees the slot being overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_output_stage.sv
// Decimates the FIR result, then rounds, shifts and saturates it and buffers it for a valid/ready consumer.
// Latency: kept valid_in sampled at edge n+1 into the stage register, then written to the FIFO at edge n+2.
// Backpressure: none upstream. A kept sample meeting a full FIFO with no read is dropped and ovf_sticky is set.
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int          DIN_WIDTH  = 26,
    parameter int          DOUT_WIDTH = 16,
    parameter int          SHIFT      = 10,
    parameter round_mode_e ROUND_MODE = ROUND_HALF_UP,
    parameter int          DECIM      = 1,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [DIN_WIDTH-1:0]  din,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DOUT_WIDTH-1:0] m_data,
    input  logic                         clr_status,
    output logic                         sat_sticky,
    output logic                         ovf_sticky
);
    localparam int                      EXT_W   = DIN_WIDTH + 1;
    localparam int                      RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] RND_ADD =
        ((ROUND_MODE == ROUND_HALF_UP) && (SHIFT > 0)) ? (EXT_W'(1) << RND_POS) : '0;

    logic                    keep;
    logic signed [EXT_W-1:0] din_ext;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;
    sat_res_t                sat_r;
    logic                    unused_sat_hi;

    logic                    stage_vld;
    logic [DOUT_WIDTH-1:0]   stage_dat;
    logic                    stage_sat;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_rd;
    logic                    fifo_wr;
    logic                    drop;

    generate
        if (DECIM > 1) begin : g_decim
            localparam int PHW = $clog2(DECIM);
            logic [PHW-1:0] phase;

            // Phase advances only on valid_in. Gaps in the stream do not consume a phase.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    phase <= '0;
                end else if (valid_in) begin
                    phase <= (phase == PHW'(DECIM - 1)) ? '0 : phase + PHW'(1);
                end
            end

            assign keep = valid_in && (phase == '0);
        end else begin : g_nodecim
            assign keep = valid_in;
        end
    endgenerate

    // Requantise: widen by one bit so the rounding add cannot wrap, then shift and clip.
    always_comb begin
        din_ext = {din[DIN_WIDTH-1], din};
        rounded = din_ext + RND_ADD;
        shifted = rounded >>> SHIFT;
        sat_r   = sat_signed({{(SAT_MAX_W - EXT_W){shifted[EXT_W-1]}}, shifted}, DOUT_WIDTH);
    end

    // After clipping, the bits above DOUT_WIDTH are only sign copies and carry no information.
    assign unused_sat_hi = ^sat_r.value[SAT_MAX_W-1:DOUT_WIDTH];

    // Single requant register. The sat flag travels with its sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= 1'b0;
            stage_dat <= '0;
            stage_sat <= 1'b0;
        end else begin
            stage_vld <= keep;
            if (keep) begin
                stage_dat <= sat_r.value[DOUT_WIDTH-1:0];
                stage_sat <= sat_r.ovf;
            end
        end
    end

    // A read in the same cycle frees a slot, so a full FIFO only drops when nothing drains.
    assign fifo_rd = m_ready && !fifo_empty;
    assign drop    = stage_vld && fifo_full && !fifo_rd;
    assign fifo_wr = stage_vld && !drop;
    assign m_valid = !fifo_empty;

    fir_sample_fifo #(
        .WIDTH (DOUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (stage_dat),
        .rd_en   (fifo_rd),
        .rd_data (m_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sticky status. A new event in the same cycle as clr_status wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            sat_sticky <= (fifo_wr && stage_sat) || (sat_sticky && !clr_status);
            ovf_sticky <= drop || (ovf_sticky && !clr_status);
        end
    end

endmodule

// File: tb/tb_fir_output_stage.sv
`timescale 1ns/1ps
module tb_fir_output_stage;
    import fir_pkg::*;

    localparam int DIN_W  = 26;
    localparam int DOUT_W = 16;
    localparam int DEPTH  = 4;
    localparam int NI     = 3;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          valid_in;
    logic signed [DIN_W-1:0]       din;
    logic                          m_ready;
    logic                          clr_status;
    logic [NI-1:0]                 m_valid;
    logic [NI-1:0]                 sat_sticky;
    logic [NI-1:0]                 ovf_sticky;
    logic [NI-1:0][DOUT_W-1:0]     m_data;

    int errors = 0;
    int checks = 0;

    // Instance 0: round half-up, no decimation. Instance 1: truncate. Instance 2: DECIM=3.
    int decim_cfg [NI] = '{1, 1, 3};
    int rnd_cfg   [NI] = '{1, 0, 1};

    // Behavioural reference state.
    int phase  [NI];
    bit st_v   [NI];
    int st_d   [NI];
    bit st_sat [NI];
    int fq     [NI][DEPTH];
    int fcnt   [NI];
    bit e_sat  [NI];
    bit e_ovf  [NI];
    int dec_got[$];

    always #5 clk = ~clk;

    fir_output_stage #(.DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W), .SHIFT(10),
                       .ROUND_MODE(ROUND_HALF_UP), .DECIM(1), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
        .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
        .clr_status(clr_status), .sat_sticky(sat_sticky[0]), .ovf_sticky(ovf_sticky[0]));

    fir_output_stage #(.DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W), .SHIFT(10),
                       .ROUND_MODE(ROUND_TRUNC), .DECIM(1), .FIFO_DEPTH(DEPTH)) u_trunc (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
        .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
        .clr_status(clr_status), .sat_sticky(sat_sticky[1]), .ovf_sticky(ovf_sticky[1]));

    fir_output_stage #(.DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W), .SHIFT(10),
                       .ROUND_MODE(ROUND_HALF_UP), .DECIM(3), .FIFO_DEPTH(DEPTH)) u_dec (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din),
        .m_valid(m_valid[2]), .m_ready(m_ready), .m_data(m_data[2]),
        .clr_status(clr_status), .sat_sticky(sat_sticky[2]), .ovf_sticky(ovf_sticky[2]));

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Requantised value of x: optional +512, floor divide by 1024, clip to 16-bit signed.
    function automatic int requant(input int x, input int rm, output bit sat);
        longint v;
        v   = longint'(x) + (rm != 0 ? 512 : 0);
        v   = v >>> 10;
        sat = 1'b0;
        if (v > 32767) begin
            v   = 32767;
            sat = 1'b1;
        end else if (v < -32768) begin
            v   = -32768;
            sat = 1'b1;
        end
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            phase[i] = 0; st_v[i] = 0; st_d[i] = 0; st_sat[i] = 0;
            fcnt[i] = 0; e_sat[i] = 0; e_ovf[i] = 0;
        end
    endtask

    // One clock edge of the reference: consume, then store or drop, then capture new input.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            bit rd;
            bit sat_set;
            bit ovf_set;
            bit s;
            rd      = m_ready && (fcnt[i] > 0);
            sat_set = 0;
            ovf_set = 0;
            if (rd) begin
                for (int j = 0; j < DEPTH - 1; j++) fq[i][j] = fq[i][j+1];
                fcnt[i]--;
            end
            if (st_v[i]) begin
                if (fcnt[i] == DEPTH) begin
                    ovf_set = 1;
                end else begin
                    fq[i][fcnt[i]] = st_d[i];
                    fcnt[i]++;
                    sat_set = st_sat[i];
                end
            end
            e_sat[i] = sat_set || (e_sat[i] && !clr_status);
            e_ovf[i] = ovf_set || (e_ovf[i] && !clr_status);
            st_v[i]  = 0;
            if (valid_in) begin
                if (phase[i] == 0) begin
                    st_v[i] = 1;
                    st_d[i] = requant(int'(din), rnd_cfg[i], s);
                    st_sat[i] = s;
                end
                phase[i] = (phase[i] + 1) % decim_cfg[i];
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d_m_valid", i), m_valid[i], fcnt[i] > 0);
            check($sformatf("u%0d_m_data", i), $signed(m_data[i]), (fcnt[i] > 0) ? fq[i][0] : 0);
            check($sformatf("u%0d_sat_sticky", i), sat_sticky[i], e_sat[i]);
            check($sformatf("u%0d_ovf_sticky", i), ovf_sticky[i], e_ovf[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
        if (m_valid[2] && m_ready) dec_got.push_back(int'($signed(m_data[2])));
    endtask

    task automatic send(input int x);
        valid_in = 1'b1;
        din      = DIN_W'(x);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic reset_pulse();
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; din = '0; m_ready = 1'b1; clr_status = 1'b0;
        model_reset();
        #1;
        check("reset_m_valid", m_valid[0], 0);
        check("reset_m_data", $signed(m_data[0]), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Rounding and truncation, two cycles from valid_in to output.
        send(1536);
        check("lat_not_yet", m_valid[0], 0);
        tick();
        check("rnd_1536", $signed(m_data[0]), 2);
        check("trunc_1536", $signed(m_data[1]), 1);
        tick();
        send(-1536); tick();
        check("rnd_m1536", $signed(m_data[0]), -1);
        check("trunc_m1536", $signed(m_data[1]), -2);
        tick();
        send(1535); tick();
        check("rnd_1535", $signed(m_data[0]), 1);
        tick();
        send(-1); tick();
        check("trunc_m1", $signed(m_data[1]), -1);
        check("rnd_m1", $signed(m_data[0]), 0);
        tick();

        // Saturation and sticky clear.
        send(33554431); tick();
        check("sat_pos_data", $signed(m_data[0]), 32767);
        check("sat_pos_flag", sat_sticky[0], 1);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        check("sat_cleared", sat_sticky[0], 0);
        send(-33554432); tick();
        check("sat_neg_data", $signed(m_data[0]), -32768);
        check("sat_neg_flag", sat_sticky[0], 0);
        tick();

        // Decimation by 3 with gaps in valid_in.
        reset_pulse();
        dec_got.delete();
        for (int k = 1; k <= 6; k++) begin
            send(k * 1024);
            if (k % 2 == 1) tick();
        end
        tick(); tick(); tick();
        check("decim_count", dec_got.size(), 2);
        check("decim_first", (dec_got.size() > 0) ? dec_got[0] : -99999, 1);
        check("decim_second", (dec_got.size() > 1) ? dec_got[1] : -99999, 4);

        // Backpressure: four held, two dropped.
        reset_pulse();
        m_ready = 1'b0;
        for (int k = 1; k <= 6; k++) send(k * 1024);
        tick(); tick();
        check("bp_valid", m_valid[0], 1);
        check("bp_head", $signed(m_data[0]), 1);
        check("bp_ovf", ovf_sticky[0], 1);
        m_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("bp_drain_%0d", k), $signed(m_data[0]), k);
        end
        tick();
        check("bp_empty", m_valid[0], 0);

        // Full FIFO with simultaneous read and write keeps every sample.
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(k * 1024);
        tick();
        clr_status = 1'b1; valid_in = 1'b1; din = DIN_W'(5 * 1024); tick();
        clr_status = 1'b0; m_ready = 1'b1; din = DIN_W'(6 * 1024); tick();
        valid_in = 1'b0; tick();
        m_ready = 1'b0;
        check("rw_full_ovf", ovf_sticky[0], 0);
        check("rw_full_head", $signed(m_data[0]), 3);
        m_ready = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            tick();
            check($sformatf("rw_drain_%0d", k), $signed(m_data[0]), k);
        end
        tick();
        check("rw_empty", m_valid[0], 0);

        // Reset between edges with entries queued.
        m_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(k * 1024);
        tick();
        check("mid_queued", m_valid[0], 1);
        reset_pulse();
        check("mid_rst_valid", m_valid[0], 0);
        m_ready = 1'b1;
        send(7 * 1024);
        check("post_rst_not_yet", m_valid[2], 0);
        tick();
        check("post_rst_kept", m_valid[2], 1);
        check("post_rst_data", $signed(m_data[2]), 7);
        tick();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel        = $urandom_range(0, 9);
            valid_in   = ($urandom_range(0, 3) != 0);
            if (sel == 0)      din = DIN_W'(33554431);
            else if (sel == 1) din = DIN_W'(-33554432);
            else if (sel < 5)  din = DIN_W'($urandom_range(0, 4000)) - DIN_W'(2000);
            else               din = DIN_W'($urandom);
            m_ready    = ($urandom_range(0, 2) != 0);
            clr_status = ($urandom_range(0, 15) == 0);
            tick();
        end
        valid_in = 1'b0; clr_status = 1'b0; m_ready = 1'b1;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
